mbist_fail_logger: RTL and testbench
====================================

# mbist_fail_logger

Downstream capture stage for the MBIST decoder. Every cycle the decoder flags a read mismatch, this block counts the error and pushes a diagnostic entry into a small FIFO: failing address, syndrome, and algorithm ID. It compares the running error count against the allowable-fault budget and raises a sticky terminate request. A host or scan-out reader drains the FIFO through a valid/ready handshake.

## Interface
- DATA_WIDTH, 64, width of read/expected data and syndrome
- ADDR_WIDTH, 16, width of address, fail count and fault budget
- PTR_WIDTH, 3, log2 of FIFO depth (depth = 8)

- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- clear  in  1  synchronous clear of FIFO, counters and sticky flags at test start
- error  in  1  one-cycle mismatch strobe from decoder
- address  in  ADDR_WIDTH  address of the compared read, valid with error
- rdata  in  DATA_WIDTH  data read from memory, valid with error
- exp_data  in  DATA_WIDTH  expected data, valid with error
- algo_id  in  2  running algorithm: 0 MarchC, 1 MarchA, 2 APNPSF, 3 reserved
- error_exceed_ignore  in  1  1 = never request termination
- allowable_faulty  in  ADDR_WIDTH  fault budget
- force_terminate  out  1  sticky terminate request to decoder/controller
- fail_count  out  ADDR_WIDTH  saturating count of error strobes since clear
- log_valid  out  1  FIFO head entry valid
- log_ready  in  1  reader accepts head entry
- log_addr  out  ADDR_WIDTH  head entry address
- log_syndrome  out  DATA_WIDTH  head entry rdata XOR exp_data
- log_algo  out  2  head entry algo_id
- log_entries  out  PTR_WIDTH+1  current FIFO occupancy, 0..8
- log_full  out  1  occupancy == 8
- log_overflow  out  1  sticky: an entry was dropped

## Operation
- Reset (rst_n=0 at an edge): all outputs 0, pointers 0, last-logged register invalid. clear=1 has the same effect as reset. Either one dominates error and log_ready in the same cycle.
- Count: on each error=1, fail_count increments. It saturates at all-ones and never wraps.
- Terminate: force_terminate sets when error_exceed_ignore=0 and fail_count > allowable_faulty, evaluated on the registered count. It stays set until clear/reset, including if error_exceed_ignore later rises. With allowable_faulty=all-ones it can never set.
- Repeat suppression: an error whose address and algo_id equal the most recently pushed entry (since clear) is counted but not pushed. The last-logged register updates only on an actual push.
- Push: on error=1, not suppressed, and (not full, or full with a pop in the same cycle). Writes {address, rdata^exp_data, algo_id} at the write pointer.
- Drop: error=1, not suppressed, full, and no pop. The entry is discarded and log_overflow sets (sticky). The last-logged register is not updated.
- Pop: on log_valid & log_ready; the read pointer advances.
- log_valid = (log_entries != 0). log_addr/log_syndrome/log_algo show the head entry and hold stable while log_valid=1 and log_ready=0.
- Pointers are PTR_WIDTH bits and wrap 7 -> 0. Occupancy is tracked by log_entries: +1 on push only, -1 on pop only, unchanged on both.
- When empty, pop is impossible; a push in that cycle is visible next cycle.

## Timing
- error at edge N: fail_count, log_entries, log_valid and log_full reflect it after edge N.
- force_terminate rises one edge after the fail_count update that crosses the budget, so 2 edges after the offending error.
- Pop at edge N: next head entry is presented after edge N. Back-to-back pops are sustained at 1 per cycle.
- Head entry outputs are driven from the storage array at the read pointer; no combinational path from error to log_* within a cycle.
- Throughput: 1 error per cycle accepted, no backpressure on the decoder.

## Test plan
- Reset/clear: drive errors, then rst_n=0 for one edge -> all outputs 0. Repeat with clear=1 and error=1 in the same cycle -> fail_count stays 0, log_entries 0.
- Budget: allowable_faulty=2, ignore=0, errors at addresses 0x10, 0x11, 0x12 -> fail_count=3, force_terminate=1 two edges after the third error. Same sequence with ignore=1 -> force_terminate stays 0.
- Suppression: errors at 0x20 (algo 0), 0x20 (algo 0), 0x20 (algo 1) -> fail_count=3, log_entries=2, entries {0x20,0}, {0x20,1}.
- Syndrome: rdata=0xFFFF_0000_0000_0001, exp=0xFFFF_0000_0000_0000 -> log_syndrome=0x1.
- Full/overflow: log_ready=0, 9 distinct errors -> log_full=1, log_entries=8, log_overflow=1, fail_count=9. Then 10th distinct error with log_ready=1 -> push accepted, log_entries stays 8, log_overflow stays 1.
- Wrap: 20 distinct errors with log_ready=1 every cycle -> entries read out in order with addresses matching, log_entries never exceeds 1, no overflow.

Source files
------------

// File: rtl/mbist_fail_logger.sv
// -----------------------------------------------------------------------------
// mbist_fail_logger
//
// Capture stage behind the MBIST decoder. For each mismatch strobe it:
//   - bumps a saturating fail counter,
//   - logs {address, rdata^exp_data, algo_id} into an 8-deep FIFO. A repeat of
//     the most recently logged {address, algo_id} pair is counted but not logged,
//   - raises a sticky terminate request once the registered count exceeds the
//     fault budget (unless error_exceed_ignore is set).
// A reader drains the FIFO through log_valid/log_ready.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   clear               synchronous clear, same effect as reset
//   error               one-cycle mismatch strobe
//   address, rdata,     failing read info, valid with error
//   exp_data, algo_id
//   error_exceed_ignore 1 = never request termination
//   allowable_faulty    fault budget
//   force_terminate     sticky terminate request
//   fail_count          saturating error count since clear
//   log_valid/ready     FIFO head handshake
//   log_addr, log_syndrome, log_algo   head entry (0 when empty)
//   log_entries         occupancy 0..8
//   log_full            occupancy == 8
//   log_overflow        sticky: an entry was dropped
// -----------------------------------------------------------------------------
module mbist_fail_logger #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16,
  parameter int PTR_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  error,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic [1:0]            algo_id,
  input  logic                  error_exceed_ignore,
  input  logic [ADDR_WIDTH-1:0] allowable_faulty,
  output logic                  force_terminate,
  output logic [ADDR_WIDTH-1:0] fail_count,
  output logic                  log_valid,
  input  logic                  log_ready,
  output logic [ADDR_WIDTH-1:0] log_addr,
  output logic [DATA_WIDTH-1:0] log_syndrome,
  output logic [1:0]            log_algo,
  output logic [PTR_WIDTH:0]    log_entries,
  output logic                  log_full,
  output logic                  log_overflow
);

  localparam int DEPTH = 1 << PTR_WIDTH;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] syndrome;
    logic [1:0]            algo;
  } entry_t;

  entry_t                mem_q [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0]    entries_q, entries_d;
  logic [ADDR_WIDTH-1:0] fail_count_q, fail_count_d;
  logic                  terminate_q, terminate_d;
  logic                  overflow_q, overflow_d;
  logic                  last_valid_q, last_valid_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic [1:0]            last_algo_q, last_algo_d;

  logic   sync_clr;
  logic   full;
  logic   pop;
  logic   suppress;
  logic   push;
  logic   drop;
  entry_t head;

  assign sync_clr = !rst_n || clear;
  assign full     = (entries_q == (PTR_WIDTH + 1)'(DEPTH));
  assign pop      = (entries_q != '0) && log_ready;
  assign suppress = last_valid_q && (address == last_addr_q) && (algo_id == last_algo_q);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = !sync_clr && error && !suppress && (!full || pop);
  assign drop     = error && !suppress && full && !pop;

  // NOTE: every comb output gets a default first, so no path leaves a latch.
  always_comb begin
    fail_count_d = fail_count_q;
    terminate_d  = terminate_q;
    overflow_d   = overflow_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    entries_d    = entries_q;
    last_valid_d = last_valid_q;
    last_addr_d  = last_addr_q;
    last_algo_d  = last_algo_q;

    if (error && (fail_count_q != '1)) fail_count_d = fail_count_q + 1'b1;

    // Judged on the registered count, so it lags the count update by one edge.
    if (!error_exceed_ignore && (fail_count_q > allowable_faulty)) terminate_d = 1'b1;

    if (drop) overflow_d = 1'b1;

    if (push) begin
      wr_ptr_d     = wr_ptr_q + PTR_WIDTH'(1);
      last_valid_d = 1'b1;
      last_addr_d  = address;
      last_algo_d  = algo_id;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);

    case ({push, pop})
      2'b10:   entries_d = entries_q + 1'b1;
      2'b01:   entries_d = entries_q - 1'b1;
      default: entries_d = entries_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (sync_clr) begin
      fail_count_q <= '0;
      terminate_q  <= 1'b0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      entries_q    <= '0;
      last_valid_q <= 1'b0;
      last_addr_q  <= '0;
      last_algo_q  <= '0;
    end else begin
      fail_count_q <= fail_count_d;
      terminate_q  <= terminate_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      entries_q    <= entries_d;
      last_valid_q <= last_valid_d;
      last_addr_q  <= last_addr_d;
      last_algo_q  <= last_algo_d;
    end
  end

  // NOTE: the storage array is not reset; stale contents are never visible
  // because the head outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{addr: address, syndrome: rdata ^ exp_data, algo: algo_id};
  end

  assign head            = mem_q[rd_ptr_q];
  assign log_valid       = (entries_q != '0);
  assign log_addr        = log_valid ? head.addr     : '0;
  assign log_syndrome    = log_valid ? head.syndrome : '0;
  assign log_algo        = log_valid ? head.algo     : '0;
  assign log_entries     = entries_q;
  assign log_full        = full;
  assign log_overflow    = overflow_q;
  assign fail_count      = fail_count_q;
  assign force_terminate = terminate_q;

endmodule

// File: tb/tb_mbist_fail_logger.sv
// -----------------------------------------------------------------------------
// tb_mbist_fail_logger
//
// Directed steps from the block's test plan followed by a randomized run and a
// saturation run. Expected values come from a queue-based reference model that
// applies the logging rules directly.
// -----------------------------------------------------------------------------
module tb_mbist_fail_logger;

  localparam int DW = 64;
  localparam int AW = 16;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          error;
  logic [AW-1:0] address;
  logic [DW-1:0] rdata;
  logic [DW-1:0] exp_data;
  logic [1:0]    algo_id;
  logic          error_exceed_ignore;
  logic [AW-1:0] allowable_faulty;
  logic          force_terminate;
  logic [AW-1:0] fail_count;
  logic          log_valid;
  logic          log_ready;
  logic [AW-1:0] log_addr;
  logic [DW-1:0] log_syndrome;
  logic [1:0]    log_algo;
  logic [PW:0]   log_entries;
  logic          log_full;
  logic          log_overflow;

  mbist_fail_logger #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PTR_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .error(error), .address(address),
    .rdata(rdata), .exp_data(exp_data), .algo_id(algo_id),
    .error_exceed_ignore(error_exceed_ignore), .allowable_faulty(allowable_faulty),
    .force_terminate(force_terminate), .fail_count(fail_count),
    .log_valid(log_valid), .log_ready(log_ready), .log_addr(log_addr),
    .log_syndrome(log_syndrome), .log_algo(log_algo), .log_entries(log_entries),
    .log_full(log_full), .log_overflow(log_overflow)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] syn;
    logic [1:0]    algo;
  } ent_t;

  ent_t          m_q[$];
  int            m_count;
  bit            m_term;
  bit            m_ovf;
  bit            m_last_v;
  logic [AW-1:0] m_last_addr;
  logic [1:0]    m_last_algo;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic model_step();
    bit was_full;
    bit do_pop;
    if (!rst_n || clear) begin
      m_q.delete();
      m_count  = 0;
      m_term   = 0;
      m_ovf    = 0;
      m_last_v = 0;
      return;
    end
    // Budget is judged on the count as it stood before this edge.
    if (!error_exceed_ignore && (m_count > int'(allowable_faulty))) m_term = 1;
    was_full = (m_q.size() == 8);
    do_pop   = (m_q.size() != 0) && log_ready;
    if (do_pop) void'(m_q.pop_front());
    if (error) begin
      if (m_count < 65535) m_count++;
      if (!(m_last_v && address == m_last_addr && algo_id == m_last_algo)) begin
        if (!was_full || do_pop) begin
          m_q.push_back('{addr: address, syn: rdata ^ exp_data, algo: algo_id});
          m_last_v    = 1;
          m_last_addr = address;
          m_last_algo = algo_id;
        end else begin
          m_ovf = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    bit v;
    v = (m_q.size() != 0);
    chk("fail_count",      64'(fail_count),      64'(m_count));
    chk("force_terminate", 64'(force_terminate), 64'(m_term));
    chk("log_entries",     64'(log_entries),     64'(m_q.size()));
    chk("log_valid",       64'(log_valid),       64'(v));
    chk("log_full",        64'(log_full),        64'(m_q.size() == 8));
    chk("log_overflow",    64'(log_overflow),    64'(m_ovf));
    chk("log_addr",        64'(log_addr),        v ? 64'(m_q[0].addr) : 64'd0);
    chk("log_syndrome",    64'(log_syndrome),    v ? m_q[0].syn       : 64'd0);
    chk("log_algo",        64'(log_algo),        v ? 64'(m_q[0].algo) : 64'd0);
  endtask

  // Drive one cycle's inputs, clock it, update the model, sample #1 later.
  task automatic cyc(input bit err, input logic [AW-1:0] a, input logic [DW-1:0] rd,
                     input logic [DW-1:0] ex, input logic [1:0] alg, input bit rdy);
    error     = err;
    address   = a;
    rdata     = rd;
    exp_data  = ex;
    algo_id   = alg;
    log_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input bit rdy);
    cyc(1'b0, '0, '0, '0, 2'd0, rdy);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    idle(1'b0);
    clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; error = 1'b0; address = '0; rdata = '0; exp_data = '0;
    algo_id = '0; log_ready = 1'b0; error_exceed_ignore = 1'b0; allowable_faulty = 16'd100;

    // Reset state
    idle(1'b0);
    idle(1'b0);
    rst_n = 1'b1;
    chk("reset_fail_count", 64'(fail_count), 64'd0);
    chk("reset_valid", 64'(log_valid), 64'd0);

    // Errors then reset for one edge
    cyc(1'b1, 16'h0001, 64'h5, 64'h0, 2'd0, 1'b0);
    cyc(1'b1, 16'h0002, 64'h6, 64'h0, 2'd1, 1'b0);
    rst_n = 1'b0;
    cyc(1'b1, 16'h0003, 64'h7, 64'h0, 2'd2, 1'b1);
    rst_n = 1'b1;
    chk("rst_dom_fail_count", 64'(fail_count), 64'd0);
    chk("rst_dom_entries", 64'(log_entries), 64'd0);

    // Clear with error in the same cycle
    cyc(1'b1, 16'h0004, 64'h1, 64'h0, 2'd0, 1'b0);
    clear = 1'b1;
    cyc(1'b1, 16'h0005, 64'h1, 64'h0, 2'd0, 1'b0);
    clear = 1'b0;
    chk("clr_dom_fail_count", 64'(fail_count), 64'd0);
    chk("clr_dom_entries", 64'(log_entries), 64'd0);

    // Budget crossing, terminate two edges after third error
    allowable_faulty = 16'd2; error_exceed_ignore = 1'b0;
    cyc(1'b1, 16'h0010, 64'h1, 64'h0, 2'd0, 1'b0);
    cyc(1'b1, 16'h0011, 64'h1, 64'h0, 2'd0, 1'b0);
    cyc(1'b1, 16'h0012, 64'h1, 64'h0, 2'd0, 1'b0);
    chk("budget_count3", 64'(fail_count), 64'd3);
    chk("budget_term_not_yet", 64'(force_terminate), 64'd0);
    idle(1'b0);
    chk("budget_term_set", 64'(force_terminate), 64'd1);
    error_exceed_ignore = 1'b1;
    idle(1'b0);
    chk("budget_term_sticky", 64'(force_terminate), 64'd1);
    do_clear();
    cyc(1'b1, 16'h0010, 64'h1, 64'h0, 2'd0, 1'b0);
    cyc(1'b1, 16'h0011, 64'h1, 64'h0, 2'd0, 1'b0);
    cyc(1'b1, 16'h0012, 64'h1, 64'h0, 2'd0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("ignore_term_low", 64'(force_terminate), 64'd0);
    error_exceed_ignore = 1'b0;
    allowable_faulty = 16'd100;

    // Repeat suppression
    do_clear();
    cyc(1'b1, 16'h0020, 64'h3, 64'h0, 2'd0, 1'b0);
    cyc(1'b1, 16'h0020, 64'h3, 64'h0, 2'd0, 1'b0);
    cyc(1'b1, 16'h0020, 64'h3, 64'h0, 2'd1, 1'b0);
    chk("supp_count", 64'(fail_count), 64'd3);
    chk("supp_entries", 64'(log_entries), 64'd2);
    chk("supp_head_algo0", 64'(log_algo), 64'd0);
    idle(1'b1);
    chk("supp_head2_addr", 64'(log_addr), 64'h20);
    chk("supp_head2_algo1", 64'(log_algo), 64'd1);

    // Syndrome
    do_clear();
    cyc(1'b1, 16'h0030, 64'hFFFF_0000_0000_0001, 64'hFFFF_0000_0000_0000, 2'd2, 1'b0);
    chk("syndrome_bit0", log_syndrome, 64'h1);

    // Full and overflow
    do_clear();
    for (int i = 0; i < 9; i++)
      cyc(1'b1, 16'h0040 + 16'(i), {$urandom, $urandom}, {$urandom, $urandom}, 2'(i), 1'b0);
    chk("full_flag", 64'(log_full), 64'd1);
    chk("full_entries", 64'(log_entries), 64'd8);
    chk("full_overflow", 64'(log_overflow), 64'd1);
    chk("full_count", 64'(fail_count), 64'd9);
    cyc(1'b1, 16'h0050, 64'h9, 64'h0, 2'd3, 1'b1);
    chk("full_pop_push_entries", 64'(log_entries), 64'd8);
    chk("full_pop_push_ovf", 64'(log_overflow), 64'd1);
    chk("full_new_head", 64'(log_addr), 64'h41);

    // Wrap with a reader accepting every cycle
    do_clear();
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 16'h0100 + 16'(i), {$urandom, $urandom}, {$urandom, $urandom}, 2'(i % 3), 1'b1);
      chk("wrap_head_addr", 64'(log_addr), 64'h100 + 64'(i));
      chk("wrap_entries_le1", 64'(log_entries <= 1), 64'd1);
    end
    chk("wrap_no_ovf", 64'(log_overflow), 64'd0);

    // Randomized run: small address set exercises suppression
    do_clear();
    allowable_faulty = 16'($urandom_range(3, 30));
    for (int i = 0; i < 600; i++) begin
      if (i == 300) error_exceed_ignore = 1'b1;
      clear = ($urandom_range(0, 99) < 2);
      cyc($urandom_range(0, 99) < 60, 16'($urandom_range(0, 3)), {$urandom, $urandom},
          {$urandom, $urandom}, 2'($urandom_range(0, 3)), $urandom_range(0, 99) < 35);
    end
    clear = 1'b0;
    error_exceed_ignore = 1'b0;

    // Saturation with an all-ones budget: never terminates
    do_clear();
    allowable_faulty = 16'hFFFF;
    for (int i = 0; i < 65540; i++) cyc(1'b1, 16'h0055, 64'h1, 64'h0, 2'd0, 1'b1);
    chk("sat_count", 64'(fail_count), 64'hFFFF);
    idle(1'b1);
    chk("sat_no_term", 64'(force_terminate), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
